// File: rtl/wave_weight_serializer.sv
// wave_weight_serializer: converts signed weight vectors to sign-magnitude and emits nonzero bit-columns MSB-first
// Ports: clk/reset_n (async active-low); w_valid/w_ready/weight/load_prev capture a vector;
// stall freezes the beat stream; en/load_accum/last drive the MAC; sign/w_bit/column_idx carry the current column.
module wave_weight_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight,
  input  logic                                  load_prev,
  input  logic                                  stall,
  output logic                                  en,
  output logic                                  load_accum,
  output logic [VEC_LENGTH-1:0]                 sign,
  output logic [VEC_LENGTH-1:0]                 w_bit,
  output logic [$clog2(DATA_WIDTH)-1:0]         column_idx,
  output logic                                  last
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, SERIAL} state_t;
  state_t state, state_d;
  logic [DATA_WIDTH-1:0] mask, mask_in;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] mag, mag_in;
  logic [VEC_LENGTH-1:0] sgn, sgn_in;
  logic lp_q, first, one, acc;
  logic [CW-1:0] col;
  always_comb begin
    mask_in = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      sgn_in[j] = weight[j][DATA_WIDTH-1];
      mag_in[j] = sgn_in[j] ? ~weight[j] + 1'b1 : weight[j];
      mask_in = mask_in | mag_in[j];
    end
  end
  // last assignment wins, so col ends up at the highest set mask bit
  always_comb begin
    col = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (mask[i]) col = CW'(i);
  end
  assign one = (mask & (mask - 1'b1)) == '0;
  always_comb begin
    state_d = state;
    en = 1'b0;
    w_ready = 1'b0;
    if (state == IDLE) begin
      w_ready = 1'b1;
      if (w_valid) state_d = SERIAL;
    end else begin
      en = !stall;
      w_ready = !stall && one;
      if (!stall && one && !w_valid) state_d = IDLE;
    end
    w_ready = w_ready && reset_n;
  end
  assign acc = w_valid && w_ready;
  assign last = en && one;
  assign load_accum = en && first && lp_q;
  assign column_idx = col;
  assign sign = (state == SERIAL) ? sgn : '0;
  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++)
      w_bit[j] = (state == SERIAL) && mag[j][col];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  end
  // an all-zero vector still produces one column-0 beat so first/last framing is kept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
      mag <= '0;
      sgn <= '0;
      lp_q <= 1'b0;
      first <= 1'b0;
    end else if (acc) begin
      mask <= (mask_in == '0) ? DATA_WIDTH'(1) : mask_in;
      mag <= mag_in;
      sgn <= sgn_in;
      lp_q <= load_prev;
      first <= 1'b1;
    end else if (en) begin
      mask[col] <= 1'b0;
      first <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wave_weight_serializer.sv
// tb_wave_weight_serializer: directed and random checks against a column-list model of the serializer
module tb_wave_weight_serializer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic w_valid = 1'b0, load_prev = 1'b0, stall = 1'b0;
  logic [15:0][7:0] weight = '0;
  logic w_ready, en, load_accum, last;
  logic [15:0] sign, w_bit;
  logic [2:0] column_idx;
  typedef struct {
    logic [2:0] col;
    logic [15:0] bits;
    logic [15:0] sgn;
    logic la;
    logic last;
  } beat_t;
  beat_t q[$];
  int n_assert = 0, n_fail = 0;
  int rec[16];
  logic a;
  logic [15:0][7:0] wv, wb;
  wave_weight_serializer dut (
    .clk(clk), .reset_n(reset_n), .w_valid(w_valid), .w_ready(w_ready), .weight(weight),
    .load_prev(load_prev), .stall(stall), .en(en), .load_accum(load_accum), .sign(sign),
    .w_bit(w_bit), .column_idx(column_idx), .last(last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // expected beats: every magnitude bit position set in any lane, highest first
  task automatic push_vec(input logic [15:0][7:0] w, input logic lp);
    beat_t arr[8];
    int m[16];
    int n = 0;
    logic [15:0] s, b;
    for (int j = 0; j < 16; j++) begin
      m[j] = int'($signed(w[j]));
      if (m[j] < 0) m[j] = -m[j];
      s[j] = int'($signed(w[j])) < 0;
    end
    for (int c = 7; c >= 0; c--) begin
      for (int j = 0; j < 16; j++) b[j] = ((m[j] >> c) & 1) == 1;
      if (b != 0) begin
        arr[n] = '{col: 3'(c), bits: b, sgn: s, la: (n == 0) && lp, last: 1'b0};
        n++;
      end
    end
    if (n == 0) begin
      arr[0] = '{col: 3'd0, bits: 16'h0, sgn: s, la: lp, last: 1'b0};
      n = 1;
    end
    arr[n-1].last = 1'b1;
    for (int i = 0; i < n; i++) q.push_back(arr[i]);
  endtask
  task automatic step(input logic v, input logic [15:0][7:0] w, input logic lp, input logic st, output logic acc);
    logic er;
    beat_t b;
    @(negedge clk);
    w_valid = v;
    weight = w;
    load_prev = lp;
    stall = st;
    #1;
    er = (q.size() == 0) || (!st && q[0].last);
    chk("w_ready", 32'(w_ready), 32'(er));
    chk("en", 32'(en), 32'(q.size() != 0 && !st));
    if (q.size() != 0) begin
      b = q[0];
      chk("column_idx", 32'(column_idx), 32'(b.col));
      chk("sign", 32'(sign), 32'(b.sgn));
      chk("w_bit", 32'(w_bit), 32'(b.bits));
      chk("load_accum", 32'(load_accum), st ? 32'd0 : 32'(b.la));
      chk("last", 32'(last), st ? 32'd0 : 32'(b.last));
      if (!st) begin
        for (int j = 0; j < 16; j++)
          if (w_bit[j]) rec[j] += sign[j] ? -(1 << column_idx) : (1 << column_idx);
        void'(q.pop_front());
      end
    end
    acc = v && er;
    if (acc) push_vec(w, lp);
  endtask
  task automatic idle(input int n);
    logic x;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, x);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_en"}, 32'(en), 0);
    chk({tag, "_w_ready"}, 32'(w_ready), 0);
    chk({tag, "_last"}, 32'(last), 0);
    chk({tag, "_load_accum"}, 32'(load_accum), 0);
    chk({tag, "_sign"}, 32'(sign), 0);
    chk({tag, "_w_bit"}, 32'(w_bit), 0);
    chk({tag, "_column_idx"}, 32'(column_idx), 0);
  endtask
  initial begin
    #1;
    chk_reset("rst0");
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    // 1: all lanes 3, load_prev
    for (int j = 0; j < 16; j++) wv[j] = 8'd3;
    step(1'b1, wv, 1'b1, 1'b0, a);
    chk("t1_accept", 32'(a), 1);
    idle(4);
    // 2: -128 / +127 reconstruct
    wv = '0;
    wv[0] = 8'h80;
    wv[1] = 8'h7F;
    for (int j = 0; j < 16; j++) rec[j] = 0;
    step(1'b1, wv, 1'b0, 1'b0, a);
    idle(9);
    chk("t2_rec0", 32'(rec[0]), 32'(-128));
    chk("t2_rec1", 32'(rec[1]), 32'd127);
    // 3: all-zero vector gives one beat
    step(1'b1, '0, 1'b1, 1'b0, a);
    chk("t3_beats", 32'(q.size()), 1);
    idle(3);
    // 4: sparse vector with a second one queued behind it
    wv = '0;
    wv[0] = 8'h40;
    wv[1] = 8'h04;
    wb = '0;
    wb[3] = 8'hF9;
    step(1'b1, wv, 1'b1, 1'b0, a);
    chk("t4_beats", 32'(q.size()), 2);
    a = 1'b0;
    for (int i = 0; i < 5 && !a; i++) step(1'b1, wb, 1'b1, 1'b0, a);
    chk("t4_second_accept", 32'(a), 1);
    idle(6);
    // 5: stall after first beat
    for (int j = 0; j < 16; j++) wv[j] = 8'h0F;
    step(1'b1, wv, 1'b0, 1'b0, a);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, a);
    idle(5);
    // 6: async reset mid-vector
    wv = '0;
    wv[0] = 8'h7F;
    wv[1] = 8'h80;
    step(1'b1, wv, 1'b1, 1'b0, a);
    idle(2);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);
    // random traffic with sparse lanes, random stalls and gaps
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < 16; j++) wv[j] = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) wv = '0;
      step($urandom_range(0, 3) != 0, wv, 1'($urandom), $urandom_range(0, 3) == 0, a);
    end
    idle(12);
    chk("drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
